// File: rtl/instr_fetch.sv
// MIX instruction fetch: reads the word at PC, splits it into address/index/F/C
// fields and holds them for the effective-address stage under valid/ready.
module instr_fetch #(
    parameter int unsigned MEM_WORDS = 4000,
    parameter int unsigned PC_W      = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [30:0]     mem_data,
    input  logic            jmp_en,
    input  logic [PC_W-1:0] jmp_addr,
    output logic            ins_valid,
    input  logic            ins_ready,
    output logic [12:0]     addr_out,
    output logic [2:0]      index_out,
    output logic [5:0]      field_out,
    output logic [5:0]      opcode_out,
    output logic            bad_index,
    output logic [PC_W-1:0] pc_out
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_jmp_tgt;
    logic            r_jmp_pend;
    logic            r_mem_req;
    logic            r_ins_valid;
    logic [12:0]     r_addr;
    logic [2:0]      r_index;
    logic [5:0]      r_field;
    logic [5:0]      r_opcode;
    logic            r_bad_index;
    logic [PC_W-1:0] r_pc_out;

    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_next;

    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_pc_next = (w_pc_inc == PC_W'(MEM_WORDS)) ? '0 : w_pc_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_jmp_tgt   <= '0;
            r_jmp_pend  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_ins_valid <= 1'b0;
            r_addr      <= '0;
            r_index     <= '0;
            r_field     <= '0;
            r_opcode    <= '0;
            r_bad_index <= 1'b0;
            r_pc_out    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (jmp_en)
                        r_pc <= jmp_addr;
                    if (run) begin
                        r_state   <= REQ;
                        r_mem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (jmp_en) begin
                        r_jmp_pend <= 1'b1;
                        r_jmp_tgt  <= jmp_addr;
                    end
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_jmp_pend <= 1'b0;
                        // A jump seen at any point of the fetch (including the ack cycle)
                        // discards the word; the newest target wins.
                        if (r_jmp_pend || jmp_en) begin
                            r_pc    <= jmp_en ? jmp_addr : r_jmp_tgt;
                            r_state <= IDLE;
                        end else begin
                            r_addr      <= {mem_data[30], mem_data[29:18]};
                            r_index     <= mem_data[14:12];
                            r_bad_index <= (mem_data[17:12] > 6'd6);
                            r_field     <= mem_data[11:6];
                            r_opcode    <= mem_data[5:0];
                            r_pc_out    <= r_pc;
                            r_pc        <= w_pc_next;
                            r_ins_valid <= 1'b1;
                            r_state     <= HOLD;
                        end
                    end else if (jmp_en) begin
                        r_jmp_pend <= 1'b1;
                        r_jmp_tgt  <= jmp_addr;
                    end
                end
                HOLD: begin
                    if (jmp_en)
                        r_pc <= jmp_addr;
                    if (ins_ready) begin
                        r_ins_valid <= 1'b0;
                        if (run) begin
                            r_state   <= REQ;
                            r_mem_req <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_pc;
    assign ins_valid  = r_ins_valid;
    assign addr_out   = r_addr;
    assign index_out  = r_index;
    assign field_out  = r_field;
    assign opcode_out = r_opcode;
    assign bad_index  = r_bad_index;
    assign pc_out     = r_pc_out;

endmodule
